idu_pipe: RTL

IDU_PIPE -- requirements
Module: idu_pipe

---
 rtl/idu_pipe_pkg.sv | 62 ++++++
 rtl/idu_pipe_dec.sv | 153 +++++++++++++++
 rtl/idu_pipe.sv | 123 ++++++++++++
 3 files changed

// File: rtl/idu_pipe_pkg.sv
// Shared decode configuration: RISC-V opcode/func codes, EXU/LSU op encodings
// and the packed decode record passed from the decoder to the pipeline registers.
package idu_pipe_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_W = 7'b0011011;
    localparam logic [6:0] OPC_OP_W   = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR = 3'b100, F3_SR  = 3'b101, F3_OR  = 3'b110, F3_AND  = 3'b111;
    localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MULDIV = 7'b0000001;
    localparam logic [31:0] INS_EBREAK = 32'h0010_0073;

    localparam int EXU_SEL_W = 2;
    localparam logic [EXU_SEL_W-1:0] EXU_SEL_REG = 2'd0;  // rs1 op rs2
    localparam logic [EXU_SEL_W-1:0] EXU_SEL_IMM = 2'd1;  // rs1 op imm
    localparam logic [EXU_SEL_W-1:0] EXU_SEL_PC  = 2'd2;  // pc  op imm

    localparam int EXU_OPT_W = 6;
    localparam logic [EXU_OPT_W-1:0]
        EXU_ADD  = 6'd0,  EXU_SUB  = 6'd1,  EXU_SLL   = 6'd2,  EXU_SLT   = 6'd3,
        EXU_SLTU = 6'd4,  EXU_XOR  = 6'd5,  EXU_SRL   = 6'd6,  EXU_SRA   = 6'd7,
        EXU_OR   = 6'd8,  EXU_AND  = 6'd9,  EXU_MUL   = 6'd10, EXU_ADDW  = 6'd18,
        EXU_SUBW = 6'd19, EXU_SLLW = 6'd20, EXU_SRLW  = 6'd21, EXU_SRAW  = 6'd22,
        EXU_MULW = 6'd23, EXU_DIVW = 6'd24, EXU_DIVUW = 6'd25, EXU_REMW  = 6'd26,
        EXU_REMUW = 6'd27, EXU_BEQ = 6'd28, EXU_BNE   = 6'd29, EXU_BLT   = 6'd30,
        EXU_BGE  = 6'd31, EXU_BLTU = 6'd32, EXU_BGEU  = 6'd33;
    // MUL..REMU occupy EXU_MUL + func3 (10..17)

    localparam int LSU_OPT_W = 4;
    localparam logic [LSU_OPT_W-1:0] LSU_NOP = 4'hF;  // {3'b111,1'b1} is never a legal store

    typedef struct packed {
        logic [4:0]           rdid;
        logic [4:0]           rs1id;
        logic [4:0]           rs2id;
        logic                 rdwen;
        logic [63:0]          imm;
        logic [EXU_SEL_W-1:0] exu_src_sel;
        logic [EXU_OPT_W-1:0] exu_opt;
        logic [LSU_OPT_W-1:0] lsu_opt;
        logic                 brch;
        logic                 jal;
        logic                 jalr;
        logic                 ebreak;
        logic                 ill;
    } dec_t;

    localparam dec_t DEC_RST = '{rdid: 5'd0, rs1id: 5'd0, rs2id: 5'd0, rdwen: 1'b0, imm: 64'd0,
                                 exu_src_sel: EXU_SEL_REG, exu_opt: EXU_ADD, lsu_opt: LSU_NOP,
                                 brch: 1'b0, jal: 1'b0, jalr: 1'b0, ebreak: 1'b0, ill: 1'b0};

endpackage

// File: rtl/idu_pipe_dec.sv
// Combinational RV32/RV64 integer (+M) decoder producing one dec_t record.
module idu_dec
    import idu_pipe_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int EN_M = 1,
    parameter int EN_W = 1
) (
    input  logic [31:0] ins,
    output dec_t        dec
);

    localparam bit IS64   = (XLEN == 64);
    localparam bit W_OK   = (EN_W != 0) && IS64;
    localparam bit M_OK   = (EN_M != 0);

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
    dec_t        d;
    logic        ill;

    assign opc   = ins[6:0];
    assign f3    = ins[14:12];
    assign f7    = ins[31:25];
    assign imm_i = {{52{ins[31]}}, ins[31:20]};
    assign imm_s = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{52{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {{32{ins[31]}}, ins[31:12], 12'b0};
    assign imm_j = {{44{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    assign shamt = {58'd0, ins[25:20]};

    always_comb begin
        d   = DEC_RST;
        ill = 1'b0;
        case (opc)
            OPC_LUI: begin
                d.rdid = ins[11:7]; d.rdwen = 1'b1; d.imm = imm_u; d.exu_src_sel = EXU_SEL_IMM;
            end
            OPC_AUIPC: begin
                d.rdid = ins[11:7]; d.rdwen = 1'b1; d.imm = imm_u; d.exu_src_sel = EXU_SEL_PC;
            end
            OPC_JAL: begin
                d.rdid = ins[11:7]; d.rdwen = 1'b1; d.imm = imm_j; d.exu_src_sel = EXU_SEL_PC;
                d.jal = 1'b1;
            end
            OPC_JALR: begin
                d.rdid = ins[11:7]; d.rs1id = ins[19:15]; d.rdwen = 1'b1; d.imm = imm_i;
                d.exu_src_sel = EXU_SEL_IMM; d.jalr = 1'b1;
                ill = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                d.rs1id = ins[19:15]; d.rs2id = ins[24:20]; d.imm = imm_b; d.brch = 1'b1;
                case (f3)
                    3'b000:  d.exu_opt = EXU_BEQ;
                    3'b001:  d.exu_opt = EXU_BNE;
                    3'b100:  d.exu_opt = EXU_BLT;
                    3'b101:  d.exu_opt = EXU_BGE;
                    3'b110:  d.exu_opt = EXU_BLTU;
                    3'b111:  d.exu_opt = EXU_BGEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                d.rdid = ins[11:7]; d.rs1id = ins[19:15]; d.rdwen = 1'b1; d.imm = imm_i;
                d.exu_src_sel = EXU_SEL_IMM; d.lsu_opt = {f3, 1'b0};
                ill = (f3 == 3'b111) || (!IS64 && (f3 == 3'b011 || f3 == 3'b110));
            end
            OPC_STORE: begin
                d.rs1id = ins[19:15]; d.rs2id = ins[24:20]; d.imm = imm_s;
                d.exu_src_sel = EXU_SEL_IMM; d.lsu_opt = {f3, 1'b1};
                ill = f3[2] || (!IS64 && f3 == 3'b011);
            end
            OPC_OP_IMM: begin
                d.rdid = ins[11:7]; d.rs1id = ins[19:15]; d.rdwen = 1'b1; d.imm = imm_i;
                d.exu_src_sel = EXU_SEL_IMM;
                case (f3)
                    F3_ADD:  d.exu_opt = EXU_ADD;
                    F3_SLT:  d.exu_opt = EXU_SLT;
                    F3_SLTU: d.exu_opt = EXU_SLTU;
                    F3_XOR:  d.exu_opt = EXU_XOR;
                    F3_OR:   d.exu_opt = EXU_OR;
                    F3_AND:  d.exu_opt = EXU_AND;
                    F3_SLL: begin
                        d.exu_opt = EXU_SLL; d.imm = shamt;
                        ill = (ins[31:26] != 6'd0) || (!IS64 && ins[25]);
                    end
                    default: begin
                        // ins[30] selects arithmetic shift; everything else above shamt must be 0
                        d.exu_opt = ins[30] ? EXU_SRA : EXU_SRL; d.imm = shamt;
                        ill = ({ins[31], ins[29:26]} != 5'd0) || (!IS64 && ins[25]);
                    end
                endcase
            end
            OPC_OP: begin
                d.rdid = ins[11:7]; d.rs1id = ins[19:15]; d.rs2id = ins[24:20]; d.rdwen = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  d.exu_opt = EXU_ADD;
                        F3_SLL:  d.exu_opt = EXU_SLL;
                        F3_SLT:  d.exu_opt = EXU_SLT;
                        F3_SLTU: d.exu_opt = EXU_SLTU;
                        F3_XOR:  d.exu_opt = EXU_XOR;
                        F3_SR:   d.exu_opt = EXU_SRL;
                        F3_OR:   d.exu_opt = EXU_OR;
                        default: d.exu_opt = EXU_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) d.exu_opt = EXU_SUB;
                else if (f7 == F7_ALT && f3 == F3_SR)      d.exu_opt = EXU_SRA;
                else if (f7 == F7_MULDIV && M_OK)          d.exu_opt = EXU_MUL + {3'd0, f3};
                else                                       ill = 1'b1;
            end
            OPC_OP_IMM_W: begin
                d.rdid = ins[11:7]; d.rs1id = ins[19:15]; d.rdwen = 1'b1; d.imm = imm_i;
                d.exu_src_sel = EXU_SEL_IMM;
                if (f3 == F3_ADD)                                 d.exu_opt = EXU_ADDW;
                else if (f3 == F3_SLL && f7 == F7_BASE)           begin d.exu_opt = EXU_SLLW; d.imm = shamt; end
                else if (f3 == F3_SR && f7 == F7_BASE)            begin d.exu_opt = EXU_SRLW; d.imm = shamt; end
                else if (f3 == F3_SR && f7 == F7_ALT)             begin d.exu_opt = EXU_SRAW; d.imm = shamt; end
                else                                              ill = 1'b1;
                if (!W_OK) ill = 1'b1;
            end
            OPC_OP_W: begin
                d.rdid = ins[11:7]; d.rs1id = ins[19:15]; d.rs2id = ins[24:20]; d.rdwen = 1'b1;
                case ({f7, f3})
                    {F7_BASE, F3_ADD}:     d.exu_opt = EXU_ADDW;
                    {F7_BASE, F3_SLL}:     d.exu_opt = EXU_SLLW;
                    {F7_BASE, F3_SR}:      d.exu_opt = EXU_SRLW;
                    {F7_ALT, F3_ADD}:      d.exu_opt = EXU_SUBW;
                    {F7_ALT, F3_SR}:       d.exu_opt = EXU_SRAW;
                    {F7_MULDIV, 3'b000}:   begin d.exu_opt = EXU_MULW;  ill = !M_OK; end
                    {F7_MULDIV, 3'b100}:   begin d.exu_opt = EXU_DIVW;  ill = !M_OK; end
                    {F7_MULDIV, 3'b101}:   begin d.exu_opt = EXU_DIVUW; ill = !M_OK; end
                    {F7_MULDIV, 3'b110}:   begin d.exu_opt = EXU_REMW;  ill = !M_OK; end
                    {F7_MULDIV, 3'b111}:   begin d.exu_opt = EXU_REMUW; ill = !M_OK; end
                    default:               ill = 1'b1;
                endcase
                if (!W_OK) ill = 1'b1;
            end
            OPC_SYSTEM: begin
                if (ins == INS_EBREAK) d.ebreak = 1'b1;
                else                   ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        dec = d;
        if (ill) begin
            dec     = DEC_RST;
            dec.ill = 1'b1;
        end
    end

endmodule

// File: rtl/idu_pipe.sv
// Decode stage: combinational decode into a registered output with a one-entry
// skid buffer, so o_pre_ready depends only on registered state.
module idu_pipe
    import idu_pipe_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int EN_M = 1,
    parameter int EN_W = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_pre_valid,
    output logic                 o_pre_ready,
    input  logic [31:0]          i_ins,
    input  logic [XLEN-1:0]      i_pc,
    input  logic                 i_flush,
    output logic                 o_post_valid,
    input  logic                 i_post_ready,
    output logic [XLEN-1:0]      o_pc,
    output logic [4:0]           o_rdid,
    output logic [4:0]           o_rs1id,
    output logic [4:0]           o_rs2id,
    output logic                 o_rdwen,
    output logic [XLEN-1:0]      o_imm,
    output logic [EXU_SEL_W-1:0] o_exu_src_sel,
    output logic [EXU_OPT_W-1:0] o_exu_opt,
    output logic [LSU_OPT_W-1:0] o_lsu_opt,
    output logic                 o_brch,
    output logic                 o_jal,
    output logic                 o_jalr,
    output logic                 o_ebreak,
    output logic                 o_ill
);

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

    state_t          state, state_nxt;
    logic            pre_ready_p1, vld_p1, accept, drain;
    logic            load_out, load_skid, out_from_skid;
    dec_t            dec_p0, out_dec_p1, skid_dec_p1;
    logic [XLEN-1:0] out_pc_p1, skid_pc_p1;

    idu_dec #(.XLEN(XLEN), .EN_M(EN_M), .EN_W(EN_W)) u_dec (.ins(i_ins), .dec(dec_p0));

    assign vld_p1 = (state != ST_EMPTY);
    assign accept = i_pre_valid && pre_ready_p1;
    assign drain  = vld_p1 && i_post_ready;

    always_comb begin
        state_nxt     = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state)
            ST_EMPTY: if (accept) begin state_nxt = ST_FULL; load_out = 1'b1; end
            ST_FULL: begin
                if (accept && !drain)      begin state_nxt = ST_SKID; load_skid = 1'b1; end
                else if (!accept && drain) state_nxt = ST_EMPTY;
                else if (accept && drain)  load_out = 1'b1;
            end
            ST_SKID: if (drain) begin state_nxt = ST_FULL; out_from_skid = 1'b1; end
            default: state_nxt = ST_EMPTY;
        endcase
        if (i_flush) begin
            state_nxt     = ST_EMPTY;
            load_out      = 1'b0;
            load_skid     = 1'b0;
            out_from_skid = 1'b0;
        end
    end

    // ---- stage p1: state, registered ready, output and skid registers ----
    // Ready is registered from the next state so it stays 0 through reset and
    // rises on the first edge after release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_EMPTY;
            pre_ready_p1 <= 1'b0;
        end else begin
            state        <= state_nxt;
            pre_ready_p1 <= (state_nxt != ST_SKID);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_dec_p1  <= DEC_RST;
            out_pc_p1   <= '0;
            skid_dec_p1 <= DEC_RST;
            skid_pc_p1  <= '0;
        end else begin
            if (load_out) begin
                out_dec_p1 <= dec_p0;
                out_pc_p1  <= i_pc;
            end else if (out_from_skid) begin
                out_dec_p1 <= skid_dec_p1;
                out_pc_p1  <= skid_pc_p1;
            end
            if (load_skid) begin
                skid_dec_p1 <= dec_p0;
                skid_pc_p1  <= i_pc;
            end
        end
    end

    assign o_pre_ready   = pre_ready_p1;
    assign o_post_valid  = vld_p1;
    assign o_pc          = out_pc_p1;
    assign o_rdid        = out_dec_p1.rdid;
    assign o_rs1id       = out_dec_p1.rs1id;
    assign o_rs2id       = out_dec_p1.rs2id;
    assign o_rdwen       = out_dec_p1.rdwen;
    assign o_imm         = out_dec_p1.imm[XLEN-1:0];
    assign o_exu_src_sel = out_dec_p1.exu_src_sel;
    assign o_exu_opt     = out_dec_p1.exu_opt;
    assign o_lsu_opt     = out_dec_p1.lsu_opt;
    assign o_brch        = out_dec_p1.brch;
    assign o_jal         = out_dec_p1.jal;
    assign o_jalr        = out_dec_p1.jalr;
    assign o_ebreak      = out_dec_p1.ebreak;
    assign o_ill         = out_dec_p1.ill;

endmodule
